// File: rtl/load_down_timer_if.sv
// Control and status bundle for load_down_timer: strobes and mode in,
// registered count/busy/expire and FSM state out.
interface load_down_timer_if #(
    parameter int WIDTH = 4
);
    // No valid/ready handshake: every strobe is level-sampled on each rising
    // clk edge, and the outputs are valid every cycle after the edge.
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             start_i;
    logic             stop_i;
    logic             mode_i;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             expire_o;
    logic [1:0]       state_o;

    modport master (
        output load_i, load_val_i, start_i, stop_i, mode_i,
        input  count_o, busy_o, expire_o, state_o
    );

    modport slave (
        input  load_i, load_val_i, start_i, stop_i, mode_i,
        output count_o, busy_o, expire_o, state_o
    );
endinterface

// File: rtl/load_down_timer.sv
// Loadable down-counter timer with one-shot or auto-reload expiry pulse.
// Priority each cycle: load > stop > start > decrement.
module load_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    load_down_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (bus.load_i) begin
            count_d  = bus.load_val_i;
            reload_d = bus.load_val_i;
            if (state_q == RUN && bus.load_val_i == '0) begin
                state_d = IDLE;
            end
        end else if (bus.stop_i) begin
            if (state_q == RUN) begin
                state_d = HOLD;
            end
        end else if (bus.start_i && state_q != RUN) begin
            if (count_q != '0) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else begin
                // Terminal decrement; a zero count in RUN just falls back to IDLE.
                expire_d = (count_q == ONE);
                if (bus.mode_i && reload_q != '0 && count_q == ONE) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign bus.count_o  = count_q;
    assign bus.busy_o   = (state_q == RUN);
    assign bus.expire_o = expire_q;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_load_down_timer.sv
// Directed bench for load_down_timer: drivers queue hand-computed expected
// outputs, monitors pop and compare one entry per clock edge.
module tb_load_down_timer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  load_down_timer_if #(.WIDTH(4)) bus4 ();
  load_down_timer_if #(.WIDTH(8)) bus8 ();

  load_down_timer #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  load_down_timer #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

  // expected {count, busy, expire}
  logic [5:0] exp4_q[$];
  string      nm4_q[$];
  logic [9:0] exp8_q[$];
  string      nm8_q[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {count,busy,expire}=%h, expected %h", nm, act, exp);
    end
  endtask

  // driver for the 4-bit instance: inputs for one cycle plus expected result after the edge
  task automatic step(input logic ld, input logic [3:0] v, input logic st, input logic sp,
                      input logic md, input logic [3:0] ec, input logic eb, input logic ee,
                      input string nm);
    @(negedge clk);
    bus4.load_i = ld;
    bus4.load_val_i = v;
    bus4.start_i = st;
    bus4.stop_i = sp;
    bus4.mode_i = md;
    exp4_q.push_back({ec, eb, ee});
    nm4_q.push_back(nm);
  endtask

  task automatic step8(input logic ld, input logic [7:0] v, input logic st,
                       input logic [7:0] ec, input logic eb, input logic ee, input string nm);
    @(negedge clk);
    bus8.load_i = ld;
    bus8.load_val_i = v;
    bus8.start_i = st;
    exp8_q.push_back({ec, eb, ee});
    nm8_q.push_back(nm);
  endtask

  // monitors
  always @(posedge clk) begin
    #1;
    if (exp4_q.size() > 0) begin
      logic [5:0] e;
      string nm;
      e = exp4_q.pop_front();
      nm = nm4_q.pop_front();
      check(nm, 16'({bus4.count_o, bus4.busy_o, bus4.expire_o}), 16'(e));
    end
    if (exp8_q.size() > 0) begin
      logic [9:0] e8;
      string nm8;
      e8 = exp8_q.pop_front();
      nm8 = nm8_q.pop_front();
      check(nm8, 16'({bus8.count_o, bus8.busy_o, bus8.expire_o}), 16'(e8));
    end
  end

  initial begin
    bus4.load_i = 0; bus4.load_val_i = 0; bus4.start_i = 0; bus4.stop_i = 0; bus4.mode_i = 0;
    bus8.load_i = 0; bus8.load_val_i = 0; bus8.start_i = 0; bus8.stop_i = 0; bus8.mode_i = 0;
    #1;
    check("reset4", 16'({bus4.count_o, bus4.busy_o, bus4.expire_o}), 16'h0);
    check("reset8", 16'({bus8.count_o, bus8.busy_o, bus8.expire_o}), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // reset mid-run at count 5
    step(1, 4'd7, 0, 0, 0, 4'd7, 0, 0, "rst_load7");
    step(0, 4'd0, 1, 0, 0, 4'd7, 1, 0, "rst_start");
    step(0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "rst_run6");
    step(0, 4'd0, 0, 0, 0, 4'd5, 1, 0, "rst_run5");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", 16'({bus4.count_o, bus4.busy_o, bus4.expire_o}), 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "rst_start_ign");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "rst_idle");

    // one-shot
    step(1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "os_load");
    step(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "os_entry");
    step(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "os_2");
    step(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "os_1");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "os_term");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "os_after1");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "os_after2");

    // auto-reload, period 4
    step(1, 4'd4, 0, 0, 1, 4'd4, 0, 0, "ar_load");
    step(0, 4'd0, 1, 0, 1, 4'd4, 1, 0, "ar_entry");
    for (int i = 1; i <= 20; i++) begin
      step(0, 4'd0, 0, 0, 1, 4'(4 - (i % 4)), 1, (i % 4) == 0, "ar_run");
    end
    // reload 1: expire every cycle
    step(1, 4'd1, 0, 0, 1, 4'd1, 1, 0, "ar1_load");
    for (int i = 0; i < 5; i++) begin
      step(0, 4'd0, 0, 0, 1, 4'd1, 1, 1, "ar1_run");
    end
    step(0, 4'd0, 0, 1, 1, 4'd1, 0, 0, "ar1_stop");
    step(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, "hold_load0");
    step(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "hold_start_ign");

    // pause / resume
    step(1, 4'd9, 0, 0, 0, 4'd9, 0, 0, "pr_load");
    step(0, 4'd0, 1, 0, 0, 4'd9, 1, 0, "pr_entry");
    step(0, 4'd0, 0, 0, 0, 4'd8, 1, 0, "pr_8");
    step(0, 4'd0, 0, 0, 0, 4'd7, 1, 0, "pr_7");
    step(0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "pr_6");
    step(0, 4'd0, 0, 1, 0, 4'd6, 0, 0, "pr_stop");
    for (int i = 0; i < 4; i++) begin
      step(0, 4'd0, 0, 0, 0, 4'd6, 0, 0, "pr_hold");
    end
    step(0, 4'd0, 1, 0, 0, 4'd6, 1, 0, "pr_resume");
    for (int i = 5; i >= 1; i--) begin
      step(0, 4'd0, 0, 0, 0, 4'(i), 1, 0, "pr_run");
    end
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "pr_term");

    // load on the terminal cycle, load 0 in RUN
    step(1, 4'd3, 0, 0, 0, 4'd3, 0, 0, "col_load3");
    step(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "col_entry");
    step(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "col_2");
    step(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, "col_1");
    step(1, 4'd7, 0, 0, 0, 4'd7, 1, 0, "col_load_term");
    step(0, 4'd0, 0, 0, 0, 4'd6, 1, 0, "col_6");
    step(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, "col_load0");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "col_idle");

    // start+stop in HOLD and in RUN
    step(1, 4'd5, 0, 0, 0, 4'd5, 0, 0, "ss_load");
    step(0, 4'd0, 1, 0, 0, 4'd5, 1, 0, "ss_entry");
    step(0, 4'd0, 0, 1, 0, 4'd5, 0, 0, "ss_stop");
    step(0, 4'd0, 1, 1, 0, 4'd5, 0, 0, "ss_both_hold");
    step(0, 4'd0, 0, 0, 0, 4'd5, 0, 0, "ss_hold");
    step(0, 4'd0, 1, 0, 0, 4'd5, 1, 0, "ss_resume");
    step(0, 4'd0, 0, 0, 0, 4'd4, 1, 0, "ss_4");
    step(0, 4'd0, 1, 1, 0, 4'd4, 0, 0, "ss_both_run");

    // mode sampled only on the terminal cycle
    step(1, 4'd2, 0, 0, 1, 4'd2, 0, 0, "md_load");
    step(0, 4'd0, 1, 0, 1, 4'd2, 1, 0, "md_entry");
    step(0, 4'd0, 0, 0, 1, 4'd1, 1, 0, "md_1");
    step(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, "md_term_oneshot");

    // 8-bit instance, one-shot from 8'hFF
    step8(1, 8'hFF, 0, 8'hFF, 0, 0, "w8_load");
    step8(0, 8'h00, 1, 8'hFF, 1, 0, "w8_entry");
    for (int i = 1; i <= 255; i++) begin
      step8(0, 8'h00, 0, 8'(255 - i), i < 255, i == 255, "w8_run");
    end
    step8(0, 8'h00, 0, 8'h00, 0, 0, "w8_after");

    for (int i = 0; i < 10 && (exp4_q.size() > 0 || exp8_q.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (exp4_q.size() > 0 || exp8_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp4_q.size() + exp8_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_down_timer.md
Name: load_down_timer

Overview:
Loadable down-counter timer. It counts a programmed value down to terminal count and flags expiry with a one-cycle pulse, in either one-shot or auto-reload mode. It is the count-down counterpart of the team's loadable up-counter, and serves as the interval/timeout generator for blocks that currently free-run an up-counter. Single clock domain.

Parameters:
WIDTH, 4, width of count, load value and reload register.

Ports:
clk  input  1  clock, all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
load_i  input  1  synchronous load strobe; writes load_val_i to the counter and to the reload register
load_val_i  input  WIDTH  value captured on load_i
start_i  input  1  start or resume counting
stop_i  input  1  pause counting
mode_i  input  1  0 = one-shot, 1 = auto-reload; sampled only on the terminal-count cycle
count_o  output  WIDTH  current count (registered)
busy_o  output  1  high while in RUN state (registered)
expire_o  output  1  one-cycle pulse on terminal count (registered)

Behaviour:
- Reset:
  - Reset is asynchronous and active-low, on reset_n.
  - While reset_n=0: count_o=0, reload register=0, state=IDLE, busy_o=0, expire_o=0.
  - Deassertion takes effect at the first rising clk edge after reset_n rises.
  - Reset mid-count discards all state and produces no expire pulse.
- States: IDLE, RUN, HOLD. busy_o=1 only in RUN.
- Per-cycle priority: load_i > stop_i > start_i > decrement.
- load_i (any state):
  - count <= load_val_i and reload <= load_val_i.
  - No decrement occurs that cycle. expire_o=0 next cycle, even if terminal count would otherwise have occurred.
  - Next state:
    - RUN stays RUN if load_val_i != 0.
    - RUN goes to IDLE if load_val_i == 0.
    - IDLE and HOLD are unchanged.
- stop_i: RUN -> HOLD with count frozen. No effect in IDLE or HOLD.
- start_i:
  - IDLE/HOLD -> RUN if count != 0.
  - Ignored if count == 0.
  - No effect in RUN.
  - The first decrement happens in the cycle after the transition into RUN; the entry cycle itself does not decrement.
- RUN, count > 1: count <= count - 1 each cycle.
- RUN, count == 1 (terminal decrement):
  - expire_o=1 for exactly the next cycle.
  - mode_i=0: count <= 0, state <= IDLE.
  - mode_i=1 and reload != 0: count <= reload, stay RUN. The period is exactly reload cycles, so reload=1 gives expire_o high every cycle.
  - mode_i=1 and reload == 0 (reachable only via reset): count <= 0, state <= IDLE.
- count never wraps below 0. RUN with count==0 is unreachable.
- Latency:
  - Load value N, start asserted at cycle 0: RUN entered at edge 1.
  - count_o shows 0 (one-shot) or the reload value (auto) after N further edges, with expire_o high in that same cycle.
- Mode change takes effect at the next terminal count only.
- Simultaneous stop_i and start_i: stop wins.

Test Plan:
- Reset check: reset_n=0 mid-run with count_o=5 -> count_o=0, busy_o=0, expire_o=0 immediately. After release, start_i alone is ignored (count 0).
- One-shot: load 4'd3, start, mode=0 -> count_o 3,3,2,1,0. expire_o high one cycle together with count 0. busy_o falls the same cycle. No further pulses.
- Auto-reload: load 4'd4, mode=1, start, run 20 cycles -> expire_o every 4 cycles, count_o sequence 4,3,2,1,4,... Then mode=1, load 4'd1 -> expire_o high every cycle.
- Pause/resume: load 4'd9, start, stop after count_o=6 -> holds 6 for 5 cycles with busy_o=0. start -> resumes 6,5,... with total expiry delayed by exactly 5 cycles plus one entry cycle.
- Collisions:
  - load 4'd7 on the terminal cycle (count 1) in RUN -> count_o=7, no expire_o, stays RUN.
  - load 4'd0 in RUN -> IDLE, count 0, no expire.
  - start+stop together in HOLD -> stays HOLD.
- Width: WIDTH=8, load 8'hFF, mode=0 -> expire_o exactly 255 cycles after RUN entry, count never wraps to 8'hFF.
